// File: rtl/store_half_unit_if.sv
// Request/memory bundle for the store-halfword unit. The unit is the slave on the
// request side (start/endereco/dado) and the master on the word-memory side.
interface store_half_unit_if #(
    parameter int ADDR_W = 32
);
    // Request: start is a one-cycle pulse, taken only while busy is low; done
    // pulses once per taken request. Memory: mem_rd stays high until mem_rvalid,
    // mem_wr stays high (address/data stable) until mem_wack; a strobe seen while
    // its request is low carries no meaning.
    logic              start;
    logic [ADDR_W-1:0] endereco;
    logic [31:0]       dado;
    logic              busy;
    logic              done;
    logic              erro_alinhamento;
    logic              overflow;
    logic [2:0]        fsm_state;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd;
    logic [31:0]       mem_rdata;
    logic              mem_rvalid;
    logic              mem_wr;
    logic [31:0]       mem_wdata;
    logic              mem_wack;

    modport slave (
        input  start, endereco, dado, mem_rdata, mem_rvalid, mem_wack,
        output busy, done, erro_alinhamento, overflow, fsm_state,
               mem_addr, mem_rd, mem_wr, mem_wdata
    );

    modport master (
        output start, endereco, dado, mem_rdata, mem_rvalid, mem_wack,
        input  busy, done, erro_alinhamento, overflow, fsm_state,
               mem_addr, mem_rd, mem_wr, mem_wdata
    );
endinterface

// File: rtl/store_half_unit.sv
// Store-halfword path: truncates a 32-bit register to 16 bits and replaces one
// halfword of a 32-bit memory word via read-modify-write.
module store_half_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    store_half_unit_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_next;

    logic              accept;
    logic              ovf_in;
    logic              hi_q;
    logic [15:0]       half_q;
    logic [31:0]       old_q;
    logic [31:0]       wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic              erro_q;
    logic              ovf_q;

    assign accept = (state == IDLE) && bus.start;

    // Value fits a signed halfword only when bits 31..15 are all copies of the sign.
    assign ovf_in = !((&bus.dado[31:15]) || !(|bus.dado[31:15]));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = bus.endereco[0] ? DONE : READ;
                end
            end
            READ: begin
                if (bus.mem_rvalid) begin
                    state_next = MERGE;
                end
            end
            MERGE: state_next = WRITE;
            WRITE: begin
                if (bus.mem_wack) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hi_q    <= 1'b0;
            half_q  <= '0;
            old_q   <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            erro_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            if (accept) begin
                hi_q   <= bus.endereco[1];
                half_q <= bus.dado[15:0];
                addr_q <= {bus.endereco[ADDR_W-1:2], 2'b00};
                erro_q <= bus.endereco[0];
                ovf_q  <= ovf_in;
            end
            if (state == READ && bus.mem_rvalid) begin
                old_q <= bus.mem_rdata;
            end
            // Little-endian: byte offset 2 selects the upper halfword.
            if (state == MERGE) begin
                wdata_q <= hi_q ? {half_q, old_q[15:0]} : {old_q[31:16], half_q};
            end
        end
    end

    assign bus.busy             = (state != IDLE);
    assign bus.done             = (state == DONE);
    assign bus.mem_rd           = (state == READ);
    assign bus.mem_wr           = (state == WRITE);
    assign bus.mem_addr         = addr_q;
    assign bus.mem_wdata        = wdata_q;
    assign bus.erro_alinhamento = erro_q;
    assign bus.overflow         = ovf_q;
    assign bus.fsm_state        = state;

endmodule

// File: tb/tb_store_half_unit.sv
// Bench for store_half_unit: driver, word-memory responder, and a monitor that
// checks each done pulse against expectations computed when the request was issued.
module tb_store_half_unit;
    localparam int ADDR_W = 32;
    localparam int EW     = 98;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    store_half_unit_if #(.ADDR_W(ADDR_W)) bus ();

    store_half_unit #(.ADDR_W(ADDR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] dut_mem [logic [31:0]];
    // {erro, ovf, word[31:0], latency[15:0], rd_cycles[7:0], wr_cycles[7:0], word_addr[31:0]}
    logic [EW-1:0] exp_q [$];

    int          rd_seen     = 0;
    int          wr_seen     = 0;
    int          cur_rd_wait = 0;
    int          cur_wr_wait = 0;
    logic [31:0] cur_waddr   = '0;
    bit          wr_hold     = 1'b0;
    int          start_cyc   = 0;
    int          ops_done    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, expv);
        end
    endtask

    function automatic logic [31:0] ref_get(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] dut_get(input logic [31:0] a);
        return dut_mem.exists(a) ? dut_mem[a] : 32'h0;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] v);
        ref_mem[a] = v;
        dut_mem[a] = v;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},      bus.busy, 0);
        check({tag, "_done"},      bus.done, 0);
        check({tag, "_erro"},      bus.erro_alinhamento, 0);
        check({tag, "_overflow"},  bus.overflow, 0);
        check({tag, "_mem_rd"},    bus.mem_rd, 0);
        check({tag, "_mem_wr"},    bus.mem_wr, 0);
        check({tag, "_mem_addr"},  bus.mem_addr, 0);
        check({tag, "_mem_wdata"}, bus.mem_wdata, 0);
        check({tag, "_state"},     bus.fsm_state, 0);
    endtask

    // Word memory with programmable wait states; strobes outside a request are noise.
    initial begin
        bus.mem_rvalid = 1'b0;
        bus.mem_wack   = 1'b0;
        bus.mem_rdata  = '0;
        forever begin
            @(negedge clock);
            bus.mem_rvalid = 1'b0;
            bus.mem_wack   = 1'b0;
            if (bus.mem_rd) begin
                rd_seen++;
                if (rd_seen > cur_rd_wait) begin
                    check("rd_addr", bus.mem_addr, cur_waddr);
                    bus.mem_rvalid = 1'b1;
                    bus.mem_rdata  = dut_get(bus.mem_addr);
                end
            end else begin
                bus.mem_rvalid = 1'($urandom_range(0, 1));
                bus.mem_rdata  = $urandom;
            end
            if (bus.mem_wr) begin
                wr_seen++;
                if (!wr_hold && wr_seen > cur_wr_wait) begin
                    check("wr_addr", bus.mem_addr, cur_waddr);
                    bus.mem_wack = 1'b1;
                    dut_mem[bus.mem_addr] = bus.mem_wdata;
                end
            end else begin
                bus.mem_wack = 1'($urandom_range(0, 1));
            end
        end
    end

    // Monitor: pops one expectation per done pulse.
    initial begin
        logic [EW-1:0] e;
        bit chk_after = 1'b0;
        forever begin
            @(negedge clock);
            if (chk_after) begin
                check("busy_after_done", bus.busy, 0);
                check("done_one_cycle", bus.done, 0);
                chk_after = 1'b0;
            end
            if (bus.done) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 required no pending request");
                end else begin
                    e = exp_q.pop_front();
                    check("erro_alinhamento", bus.erro_alinhamento, e[97]);
                    check("overflow", bus.overflow, e[96]);
                    check("mem_word", dut_get(e[31:0]), e[95:64]);
                    check("latency", cyc - start_cyc + 1, e[63:48]);
                    check("rd_cycles", rd_seen, e[47:40]);
                    check("wr_cycles", wr_seen, e[39:32]);
                    check("busy_in_done", bus.busy, 1);
                end
                ops_done++;
                chk_after = 1'b1;
            end
        end
    end

    task automatic do_op(input logic [31:0] addr, input logic [31:0] data,
                         input int rw, input int ww, input bit extra);
        logic [31:0] waddr;
        logic [31:0] old;
        logic [31:0] nw;
        bit mis;
        bit ovf;
        int sh;
        int lat;
        int rdc;
        int wrc;
        int target;
        int n;
        mis   = addr[0];
        waddr = addr & 32'hFFFF_FFFC;
        ovf   = ($signed(data) > 32767) || ($signed(data) < -32768);
        old   = ref_get(waddr);
        nw    = old;
        if (!mis) begin
            sh = addr[1] ? 16 : 0;
            nw = (old & ~(32'hFFFF << sh)) | ((data & 32'hFFFF) << sh);
            ref_mem[waddr] = nw;
        end
        lat = mis ? 1 : 4 + rw + ww;
        rdc = mis ? 0 : rw + 1;
        wrc = mis ? 0 : ww + 1;
        exp_q.push_back({mis, ovf, nw, lat[15:0], rdc[7:0], wrc[7:0], waddr});
        cur_rd_wait = rw;
        cur_wr_wait = ww;
        cur_waddr   = waddr;
        rd_seen     = 0;
        wr_seen     = 0;
        target      = ops_done + 1;
        @(negedge clock);
        bus.start    = 1'b1;
        bus.endereco = addr;
        bus.dado     = data;
        @(posedge clock);
        #1 start_cyc = cyc;
        @(negedge clock);
        bus.start    = 1'b0;
        bus.endereco = $urandom;
        bus.dado     = $urandom;
        if (extra) begin
            @(negedge clock);
            bus.start    = 1'b1;
            bus.endereco = $urandom & 32'hFFFF_FFFE;
            @(negedge clock);
            bus.start = 1'b0;
        end
        n = 0;
        while (ops_done < target && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (ops_done < target) check("done_timeout", ops_done, target);
        @(negedge clock);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int n;
        bus.start    = 1'b0;
        bus.endereco = '0;
        bus.dado     = '0;

        reset = 1'b1;
        repeat (3) @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;

        preload(32'h100, 32'h1234_5678);
        do_op(32'h100, 32'h0000_ABCD, 0, 0, 1'b0);
        preload(32'h100, 32'h1234_5678);
        do_op(32'h102, 32'h0001_FFFF, 0, 0, 1'b0);
        preload(32'h100, 32'h1234_5678);
        do_op(32'h102, 32'hFFFF_8000, 0, 0, 1'b0);
        do_op(32'h101, 32'h0000_1234, 0, 0, 1'b0);
        do_op(32'h106, 32'h0000_7FFF, 3, 2, 1'b1);

        // Reset while the write is outstanding must drop it.
        preload(32'h108, 32'hCAFE_F00D);
        wr_hold     = 1'b1;
        cur_rd_wait = 0;
        cur_wr_wait = 0;
        cur_waddr   = 32'h108;
        rd_seen     = 0;
        wr_seen     = 0;
        @(negedge clock);
        bus.start    = 1'b1;
        bus.endereco = 32'h10A;
        bus.dado     = 32'h0000_1111;
        @(negedge clock);
        bus.start = 1'b0;
        n = 0;
        while (!bus.mem_wr && n < 50) begin
            @(negedge clock);
            n++;
        end
        check("reached_write", bus.mem_wr, 1);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_all_zero("reset_in_write");
        check("word_after_reset", dut_get(32'h108), ref_get(32'h108));
        reset   = 1'b0;
        wr_hold = 1'b0;
        repeat (3) @(negedge clock);
        check("no_write_after_reset", bus.mem_wr, 0);
        check("word_still_intact", dut_get(32'h108), ref_get(32'h108));
        do_op(32'h10A, 32'h0000_1111, 1, 1, 1'b0);

        for (int i = 0; i < 30; i++) begin
            a = 32'h100 + 32'($urandom_range(0, 31));
            case ($urandom_range(0, 2))
                0:       d = $urandom & 32'h0000_7FFF;
                1:       d = $urandom | 32'hFFFF_8000;
                default: d = $urandom;
            endcase
            do_op(a, d, $urandom_range(0, 3), $urandom_range(0, 3),
                  !a[0] && ($urandom_range(0, 1) == 1));
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        repeat (5) @(negedge clock);
        check("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
